// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register for the write-back bundle.
// It also carries the multi-cycle context loop and counts inserted bubbles.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_waddr,
    input  logic                in_we,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                in_whilo,
    input  logic [DATA_W-1:0]   in_hi,
    input  logic [DATA_W-1:0]   in_lo,
    input  logic [2*DATA_W-1:0] ctx_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_waddr,
    output logic                out_we,
    output logic [DATA_W-1:0]   out_wdata,
    output logic                out_whilo,
    output logic [DATA_W-1:0]   out_hi,
    output logic [DATA_W-1:0]   out_lo,
    output logic [2*DATA_W-1:0] ctx_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [PERF_W-1:0]   bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } act_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] waddr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } wb_t;

    wb_t               bundle_q;
    wb_t               bundle_in;
    act_t              act;
    logic              s;
    logic              n;
    logic              bub_sat;
    logic [PERF_W-1:0] bub_q;

    assign s       = stall[STAGE];
    assign n       = stall[STAGE+1];
    assign bub_sat = &bub_q;

    // Conditions are written to be mutually exclusive so unique holds.
    always_comb begin
        act = ACT_HOLD;
        unique case (1'b1)
            flush:               act = ACT_FLUSH;
            (!flush && s && !n): act = ACT_BUBBLE;
            (!flush && !s):      act = ACT_ADVANCE;
            default:             act = ACT_HOLD;
        endcase
    end

    always_comb begin
        bundle_in       = '0;
        bundle_in.valid = 1'b1;
        bundle_in.waddr = in_waddr;
        bundle_in.we    = in_we;
        bundle_in.wdata = in_wdata;
        bundle_in.whilo = in_whilo;
        bundle_in.hi    = in_hi;
        bundle_in.lo    = in_lo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bundle_q <= '0;
            ctx_o    <= '0;
            cnt_o    <= '0;
            bub_q    <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH: begin
                    bundle_q <= '0;
                    ctx_o    <= '0;
                    cnt_o    <= '0;
                end
                ACT_BUBBLE: begin
                    bundle_q <= '0;
                    ctx_o    <= ctx_i;
                    cnt_o    <= cnt_i;
                    if (!bub_sat) begin
                        bub_q <= bub_q + PERF_W'(1);
                    end
                end
                ACT_ADVANCE: begin
                    bundle_q <= in_valid ? bundle_in : '0;
                    ctx_o    <= '0;
                    cnt_o    <= '0;
                end
                ACT_HOLD: begin
                    ctx_o <= ctx_i;
                    cnt_o <= cnt_i;
                end
                default: begin
                    bundle_q <= '0;
                end
            endcase
        end
    end

    assign out_valid  = bundle_q.valid;
    assign out_waddr  = bundle_q.waddr;
    assign out_we     = bundle_q.we;
    assign out_wdata  = bundle_q.wdata;
    assign out_whilo  = bundle_q.whilo;
    assign out_hi     = bundle_q.hi;
    assign out_lo     = bundle_q.lo;
    assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a cycle model and literal pins.
// A second instance with a 2-bit bubble counter exercises saturation.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_waddr;
    logic        in_we;
    logic [31:0] in_wdata;
    logic        in_whilo;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic [63:0] ctx_i;
    logic [1:0]  cnt_i;

    logic        out_valid;
    logic [4:0]  out_waddr;
    logic        out_we;
    logic [31:0] out_wdata;
    logic        out_whilo;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [63:0] ctx_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    logic        s_valid;
    logic [4:0]  s_waddr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic        s_whilo;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic [63:0] s_ctx;
    logic [1:0]  s_cnt;
    logic [1:0]  s_bub;

    int checks;
    int failures;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_waddr(in_waddr), .in_we(in_we),
        .in_wdata(in_wdata), .in_whilo(in_whilo),
        .in_hi(in_hi), .in_lo(in_lo),
        .ctx_i(ctx_i), .cnt_i(cnt_i),
        .out_valid(out_valid), .out_waddr(out_waddr),
        .out_we(out_we), .out_wdata(out_wdata),
        .out_whilo(out_whilo), .out_hi(out_hi), .out_lo(out_lo),
        .ctx_o(ctx_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.PERF_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_waddr(in_waddr), .in_we(in_we),
        .in_wdata(in_wdata), .in_whilo(in_whilo),
        .in_hi(in_hi), .in_lo(in_lo),
        .ctx_i(ctx_i), .cnt_i(cnt_i),
        .out_valid(s_valid), .out_waddr(s_waddr),
        .out_we(s_we), .out_wdata(s_wdata),
        .out_whilo(s_whilo), .out_hi(s_hi), .out_lo(s_lo),
        .ctx_o(s_ctx), .cnt_o(s_cnt), .bubble_cnt(s_bub)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: the bundle as one record, counters as plain integers.
    typedef struct {
        bit          valid;
        bit [4:0]    waddr;
        bit          we;
        bit [31:0]   wdata;
        bit          whilo;
        bit [31:0]   hi;
        bit [31:0]   lo;
    } bundle_t;

    bundle_t   m_b;
    bundle_t   nop;
    bit [63:0] m_ctx;
    bit [1:0]  m_cnt;
    int        m_bub;
    int        m_bub2;

    initial nop = '{0, 0, 0, 0, 0, 0, 0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_b = nop; m_ctx = 0; m_cnt = 0;
            m_bub = 0; m_bub2 = 0;
        end else if (flush) begin
            m_b = nop; m_ctx = 0; m_cnt = 0;
        end else if (stall[3] && !stall[4]) begin
            m_b = nop; m_ctx = ctx_i; m_cnt = cnt_i;
            m_bub = (m_bub < 65535) ? m_bub + 1 : m_bub;
            m_bub2 = (m_bub2 < 3) ? m_bub2 + 1 : m_bub2;
        end else if (!stall[3]) begin
            if (in_valid)
                m_b = '{1, in_waddr, in_we, in_wdata,
                        in_whilo, in_hi, in_lo};
            else
                m_b = nop;
            m_ctx = 0; m_cnt = 0;
        end else begin
            m_ctx = ctx_i; m_cnt = cnt_i;
        end
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("valid", 64'(out_valid), 64'(m_b.valid));
        check("waddr", 64'(out_waddr), 64'(m_b.waddr));
        check("we",    64'(out_we),    64'(m_b.we));
        check("wdata", 64'(out_wdata), 64'(m_b.wdata));
        check("whilo", 64'(out_whilo), 64'(m_b.whilo));
        check("hi",    64'(out_hi),    64'(m_b.hi));
        check("lo",    64'(out_lo),    64'(m_b.lo));
        check("ctx",   ctx_o,          m_ctx);
        check("cnt",   64'(cnt_o),     64'(m_cnt));
        check("bub",   64'(bubble_cnt), 64'(m_bub));
        check("bub2",  64'(s_bub),     64'(m_bub2));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] st, input logic fl,
                         input logic v, input logic [4:0] a,
                         input logic we, input logic [31:0] d,
                         input logic [63:0] cx, input logic [1:0] cn);
        stall = st; flush = fl; in_valid = v;
        in_waddr = a; in_we = we; in_wdata = d;
        in_whilo = we; in_hi = d ^ 32'hFFFF0000;
        in_lo = d + 32'd7; ctx_i = cx; cnt_i = cn;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        drive(6'b0, 1'b0, 1'b0, 5'h0, 1'b0, 32'h0, 64'h0, 2'd0);
        step();
        step();
        rst = 1'b1;

        // Build nonzero state, then assert reset mid-cycle.
        drive(6'b0, 1'b0, 1'b1, 5'h0A, 1'b1, 32'h1111, 64'h0, 2'd0);
        step();
        drive(6'b001000, 1'b0, 1'b1, 5'h0B, 1'b1, 32'h2222,
              64'h99, 2'd2);
        step();
        check("pre_rst_bub", 64'(bubble_cnt), 64'd1);
        drive(6'b111111, 1'b1, 1'b1, 5'h1F, 1'b1, 32'hFFFF,
              64'hFFFF, 2'd3);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctx", ctx_o, 64'd0);
        check("arst_cnt", 64'(cnt_o), 64'd0);
        check("arst_bub", 64'(bubble_cnt), 64'd0);
        step();
        rst = 1'b1;

        drive(6'b0, 1'b0, 1'b1, 5'h1F, 1'b1, 32'hDEADBEEF,
              64'h0, 2'd0);
        step();
        check("rel_waddr", 64'(out_waddr), 64'h1F);
        check("rel_wdata", 64'(out_wdata), 64'hDEADBEEF);
        check("rel_valid", 64'(out_valid), 64'd1);

        drive(6'b001000, 1'b0, 1'b1, 5'h03, 1'b1, 32'h5,
              64'h1234, 2'd1);
        step();
        check("bub_we", 64'(out_we), 64'd0);
        check("bub_valid", 64'(out_valid), 64'd0);
        check("bub_ctx", ctx_o, 64'h1234);
        check("bub_cnt", 64'(cnt_o), 64'd1);
        check("bub_1", 64'(bubble_cnt), 64'd1);
        step();
        step();
        check("bub_3", 64'(bubble_cnt), 64'd3);

        drive(6'b0, 1'b0, 1'b1, 5'h04, 1'b1, 32'hA5A5A5A5,
              64'h0, 2'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(6'b011000, 1'b0, 1'b1, 5'h09, 1'b1,
                  32'h0BAD0000 + 32'(i), 64'(i * 17 + 3), 2'(i));
            step();
            check("hold_wdata", 64'(out_wdata), 64'hA5A5A5A5);
            check("hold_ctx", ctx_o, 64'(i * 17 + 3));
        end
        check("hold_bub", 64'(bubble_cnt), 64'd3);

        drive(6'b001000, 1'b0, 1'b1, 5'h06, 1'b1, 32'h66,
              64'hCAFE, 2'd1);
        step();
        check("mc_cnt", 64'(cnt_o), 64'd1);
        check("mc_ctx", ctx_o, 64'hCAFE);
        drive(6'b0, 1'b0, 1'b1, 5'h07, 1'b1, 32'h77,
              64'hCAFE, 2'd2);
        step();
        check("mc_rel_wdata", 64'(out_wdata), 64'h77);
        check("mc_rel_ctx", ctx_o, 64'd0);
        check("mc_rel_cnt", 64'(cnt_o), 64'd0);

        drive(6'b001000, 1'b1, 1'b1, 5'h08, 1'b1, 32'h88,
              64'hBEEF, 2'd3);
        step();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_we", 64'(out_we), 64'd0);
        check("fl_ctx", ctx_o, 64'd0);
        check("fl_bub", 64'(bubble_cnt), 64'd4);

        for (int i = 0; i < 5; i++) begin
            drive(6'b001000, 1'b0, 1'b0, 5'h0, 1'b0, 32'h0,
                  64'(i), 2'd0);
            step();
        end
        check("sat_bub2", 64'(s_bub), 64'd3);
        check("sat_bub", 64'(bubble_cnt), 64'd9);

        drive(6'b0, 1'b0, 1'b0, 5'h12, 1'b1, 32'h1234,
              64'h0, 2'd0);
        step();
        check("gate_we", 64'(out_we), 64'd0);
        check("gate_valid", 64'(out_valid), 64'd0);

        drive(6'b010000, 1'b0, 1'b1, 5'h15, 1'b1, 32'h55AA,
              64'h3, 2'd1);
        step();
        check("sn_adv_wdata", 64'(out_wdata), 64'h55AA);
        check("sn_adv_ctx", ctx_o, 64'd0);

        drive(6'b0, 1'b0, 1'b0, 5'h0, 1'b0, 32'h0, 64'h0, 2'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register for the CPU core: the generalised successor of the fixed EX/MEM latch, usable at any stage boundary. It registers the write-back bundle (GPR address/enable/data plus HI/LO write) and produces a bubble when its stage stalls but the next stage does not. It also carries the multi-cycle operation context (accumulator and step count) across stalls. It adds a synchronous flush, a valid qualifier, configurable widths and stage index, and a saturating bubble-cycle counter.

## Interface
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- STALL_W, 6, width of the global stall vector
- STAGE, 3, index of this register's source stage in `stall`; STAGE+1 < STALL_W is required
- CNT_W, 2, multi-cycle step counter width
- PERF_W, 16, bubble counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  STALL_W  global stall vector, bit i = stage i stalled
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream bundle is a real instruction
- in_waddr  in  ADDR_W  GPR write address
- in_we  in  1  GPR write enable
- in_wdata  in  DATA_W  GPR write data
- in_whilo  in  1  HI/LO write enable
- in_hi, in_lo  in  DATA_W each  HI/LO write data
- ctx_i  in  2*DATA_W  multi-cycle accumulator from the execute unit
- cnt_i  in  CNT_W  multi-cycle step count from the execute unit
- out_valid  out  1  registered valid
- out_waddr, out_we, out_wdata, out_whilo, out_hi, out_lo  out  as inputs  registered bundle
- ctx_o  out  2*DATA_W  accumulator fed back to the execute unit
- cnt_o  out  CNT_W  step count fed back to the execute unit
- bubble_cnt  out  PERF_W  saturating count of bubble cycles inserted

## Operation
- Let s = stall[STAGE] and n = stall[STAGE+1]. Each rising edge takes exactly one action, in this priority order:
  1. **FLUSH** (flush=1): bundle goes to NOP (valid 0, waddr 0, we 0, wdata 0, whilo 0, hi 0, lo 0); ctx_o and cnt_o go to 0, which aborts any multi-cycle operation.
  2. **BUBBLE** (s=1, n=0): bundle goes to NOP; ctx_o <= ctx_i and cnt_o <= cnt_i; bubble_cnt increments.
  3. **ADVANCE** (s=0):
     - If in_valid=1, the bundle is captured from the inputs and out_valid <= 1.
     - If in_valid=0, the bundle goes to NOP.
     - In both cases ctx_o and cnt_o are cleared to 0.
  4. **HOLD** (s=1, n=1): bundle is unchanged; ctx_o <= ctx_i and cnt_o <= cnt_i.
- bubble_cnt saturates at all-ones; only rst clears it. Flush does not clear it.
- A NOP bundle always has out_we=0 and out_whilo=0, so downstream never writes the register file or HI/LO.
- Arithmetic: the only arithmetic is bubble_cnt + 1 at PERF_W bits, with a saturation check.

## Timing
- Reset: while rst=0, all outputs are 0, including bubble_cnt. This is asynchronous: outputs clear immediately, independent of clk. Release is sampled on the next rising edge.
- Latency: one cycle from inputs to outputs in ADVANCE.
- Context loop: ctx_i/cnt_i are visible on ctx_o/cnt_o one cycle later in BUBBLE or HOLD.
- Reset mid multi-cycle operation: ctx_o and cnt_o are 0 on release, and the operation restarts from step 0.
- Flush together with any stall pattern: FLUSH wins and bubble_cnt does not increment.
- A stall vector with s=0 and n=1 is still ADVANCE; this block does not check upstream stall consistency.

## Test plan
- **Reset:** drive rst=0 asynchronously mid-cycle with all inputs nonzero → all outputs 0 before the next edge; with rst=1, stall=0 and in_valid=1, inputs waddr=5'h1F, wdata=32'hDEADBEEF → next edge gives out_waddr=1F, out_wdata=DEADBEEF, out_valid=1.
- **Bubble:** stall=6'b001000, ctx_i=64'h1234, cnt_i=2'b01 → out_we=0, out_valid=0, ctx_o=64'h1234, cnt_o=1, bubble_cnt=1; repeat for 3 cycles → bubble_cnt=3.
- **Hold:** capture a bundle with wdata=32'hA5A5A5A5, then apply stall=6'b011000 for 4 cycles → out_wdata stays A5A5A5A5; ctx_o tracks ctx_i; bubble_cnt unchanged.
- **Multi-cycle release:** 2-step sequence — cnt_i=1, ctx_i=X under BUBBLE, then stall=0 → outputs capture the ex bundle, ctx_o=0, cnt_o=0.
- **Flush priority:** flush=1 with stall=6'b001000 and in_valid=1 → NOP bundle, ctx_o=0, cnt_o=0, bubble_cnt unchanged.
- **Saturation and valid gating:** PERF_W=2, apply 5 bubble cycles → bubble_cnt stays 3; with in_valid=0, in_we=1, stall=0 → out_we=0, out_valid=0.
